// File: rtl/lifo_buffer.sv
// Registered LIFO stack of 2**ADDR_WIDTH entries with overflow/underflow flags.
// Define LIFO_BUFFER_STICKY_ERR_EN to make OVF/UDF hold until CLR or reset.
module lifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CLR,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SP_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] SP_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] SP_TWO  = (ADDR_WIDTH + 1)'(2);

    // Handshake: PUSH and POP are single-cycle requests sampled on each rising
    // CLK edge; there is no back-pressure, refused requests raise OVF/UDF instead.

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   sp;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  is_empty;
    logic                  is_full;
    logic                  do_push;
    logic                  do_swap;
    logic                  do_pop;
    logic                  ovf_req;
    logic                  udf_req;
    logic [ADDR_WIDTH:0]   sp_m1;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] top_idx;
    logic [ADDR_WIDTH-1:0] nxt_idx;

    always_comb begin
        is_empty = (sp == '0);
        is_full  = (sp == SP_FULL);
        // Simultaneous push/pop on a non-empty stack replaces the top entry.
        do_swap  = PUSH && POP && !is_empty;
        do_push  = PUSH && !do_swap && !is_full;
        do_pop   = POP && !PUSH && !is_empty;
        ovf_req  = PUSH && !POP && is_full;
        udf_req  = POP && !PUSH && is_empty;
        sp_m1    = sp - SP_ONE;
        wr_idx   = sp[ADDR_WIDTH-1:0];
        top_idx  = ADDR_WIDTH'(sp - SP_ONE);
        nxt_idx  = ADDR_WIDTH'(sp - SP_TWO);
    end

    // Storage is not reset; DATA_OUT is only ever loaded from written entries.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            if (do_push) begin
                mem[wr_idx] <= DATA_IN;
            end else if (do_swap) begin
                mem[top_idx] <= DATA_IN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sp     <= '0;
            dout_q <= '0;
        end else if (CLR) begin
            sp     <= '0;
            dout_q <= '0;
        end else if (do_push) begin
            sp     <= sp + SP_ONE;
            dout_q <= DATA_IN;
        end else if (do_swap) begin
            dout_q <= DATA_IN;
        end else if (do_pop) begin
            sp     <= sp_m1;
            dout_q <= (sp >= SP_TWO) ? mem[nxt_idx] : '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (CLR) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
`ifdef LIFO_BUFFER_STICKY_ERR_EN
            ovf_q <= ovf_q || ovf_req;
            udf_q <= udf_q || udf_req;
`else
            ovf_q <= ovf_req;
            udf_q <= udf_req;
`endif
        end
    end

    assign DATA_OUT = dout_q;
    assign COUNT    = sp;
    assign FULL     = is_full;
    assign EMPTY    = is_empty;
    assign OVF      = ovf_q;
    assign UDF      = udf_q;

endmodule

// File: tb/tb_lifo_buffer.sv
// Self-checking bench for lifo_buffer: directed scenarios plus randomized
// traffic compared against a queue-based stack model.
module tb_lifo_buffer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    // clock / reset
    logic          clk = 1'b0;
    logic          n_rst;
    logic          clr;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;

    always #5 clk = ~clk;

    lifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK     (clk),
        .nRST    (n_rst),
        .CLR     (clr),
        .PUSH    (push),
        .POP     (pop),
        .DATA_IN (din),
        .DATA_OUT(dout),
        .COUNT   (count),
        .FULL    (full),
        .EMPTY   (empty),
        .OVF     (ovf),
        .UDF     (udf)
    );

    // scoreboard: exp_q holds the stack contents, bottom first
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf;
    logic          exp_udf;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
        int  n;
        logic hit_o, hit_u;
        n     = exp_q.size();
        hit_o = p && !q && (n == DEPTH);
        hit_u = q && !p && (n == 0);
        if (c) begin
            model_reset();
        end else begin
            if (p && q && n > 0) exp_q[n-1] = d;
            else if (p && n < DEPTH) exp_q.push_back(d);
            else if (q && !p && n > 0) void'(exp_q.pop_back());
`ifdef LIFO_BUFFER_STICKY_ERR_EN
            exp_ovf = exp_ovf || hit_o;
            exp_udf = exp_udf || hit_u;
`else
            exp_ovf = hit_o;
            exp_udf = hit_u;
`endif
        end
    endtask

    task automatic check_outputs(input string ctx);
        int n;
        logic [DW-1:0] top;
        n   = exp_q.size();
        top = (n == 0) ? '0 : exp_q[n-1];
        check({ctx, ".dout"},  32'(dout),  32'(top));
        check({ctx, ".count"}, 32'(count), n);
        check({ctx, ".full"},  32'(full),  32'(n == DEPTH));
        check({ctx, ".empty"}, 32'(empty), 32'(n == 0));
        check({ctx, ".ovf"},   32'(ovf),   32'(exp_ovf));
        check({ctx, ".udf"},   32'(udf),   32'(exp_udf));
        check({ctx, ".excl"},  32'(full && empty), 32'(0));
    endtask

    // driver: present one request, let one edge sample it, check after the edge
    task automatic step(input string ctx, input logic p, input logic q, input logic c,
                        input logic [DW-1:0] d);
        push = p;
        pop  = q;
        clr  = c;
        din  = d;
        @(posedge clk);
        model_step(p, q, c, d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        check_outputs(ctx);
    endtask

    initial begin
        int pw, qw, r;
        n_rst = 1'b0;
        clr   = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // basic push / pop ordering
        step("r31_push", 1, 0, 0, 8'h11);
        step("r31_push", 1, 0, 0, 8'h22);
        step("r31_push", 1, 0, 0, 8'h33);
        check("r31_top", 32'(dout), 32'h33);
        step("r31_pop", 0, 1, 0, 8'h00);
        check("r31_pop1", 32'(dout), 32'h22);
        step("r31_pop", 0, 1, 0, 8'h00);
        check("r31_pop2", 32'(dout), 32'h11);
        step("r31_pop", 0, 1, 0, 8'h00);
        check("r31_pop3", 32'(dout), 32'h00);
        check("r31_empty", 32'(empty), 32'd1);

        // fill and overflow
        for (int i = 1; i <= DEPTH; i++) step("r32_fill", 1, 0, 0, DW'(i));
        check("r32_full", 32'(full), 32'd1);
        step("r32_ovf", 1, 0, 0, 8'hFF);
        check("r32_ovf_flag", 32'(ovf), 32'd1);
        check("r32_ovf_dout", 32'(dout), 32'h08);
        step("r32_swap_full", 1, 1, 0, 8'hA5);
        step("r32_clr", 0, 0, 1, 8'h00);

        // underflow
        step("r33_udf", 0, 1, 0, 8'h00);
        check("r33_udf_flag", 32'(udf), 32'd1);
        step("r33_idle", 0, 0, 0, 8'h00);
        step("r33_both_empty", 1, 1, 0, 8'h44);
        check("r33_both_cnt", 32'(count), 32'd1);
        step("r33_clr", 0, 0, 1, 8'h00);
        check("r33_udf_clr", 32'(udf), 32'd0);

        // replace top
        step("r34_push", 1, 0, 0, 8'h11);
        step("r34_push", 1, 0, 0, 8'h22);
        step("r34_swap", 1, 1, 0, 8'h5A);
        check("r34_swap_dout", 32'(dout), 32'h5A);
        step("r34_pop", 0, 1, 0, 8'h00);
        check("r34_pop_dout", 32'(dout), 32'h11);
        step("r34_clr", 0, 0, 1, 8'h00);

        // asynchronous reset between edges
        for (int i = 0; i < 5; i++) step("r35_fill", 1, 0, 0, DW'(8'h60 + i));
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_outputs("r35_async");
        @(negedge clk);
        n_rst = 1'b1;
        step("r35_push", 1, 0, 0, 8'h77);
        check("r35_cnt", 32'(count), 32'd1);
        check("r35_dout", 32'(dout), 32'h77);

        // randomized traffic with alternating push/pop bias
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                pw = $urandom_range(20, 90);
                qw = $urandom_range(20, 90);
            end
            r = $urandom_range(0, 99);
            step("rand",
                 $urandom_range(0, 99) < pw,
                 $urandom_range(0, 99) < qw,
                 r < 2,
                 DW'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
